// File: rtl/mem_stage_lsu.sv
// MEM stage LSU: req/gnt/rvalid data-memory port, byte lanes, load extension.
// `define LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them.
module mem_stage_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ex_valid,
  output logic                             ex_ready,
  input  logic                             ex_mem_r,
  input  logic                             ex_mem_w,
  input  logic [2:0]                       ex_func3,
  input  logic [ADDR_W-1:0]                ex_addr,
  input  logic [XLEN-1:0]                  ex_alu,
  input  logic [XLEN-1:0]                  ex_wdata,
  input  logic [4:0]                       ex_rd,
  input  logic                             ex_reg_w,
  output logic                             dm_req,
  input  logic                             dm_gnt,
  output logic [ADDR_W-$clog2(XLEN/8)-1:0] dm_addr,
  output logic [XLEN/8-1:0]                dm_we_n,
  output logic [XLEN-1:0]                  dm_wdata,
  input  logic                             dm_rvalid,
  input  logic [XLEN-1:0]                  dm_rdata,
  output logic                             wb_valid,
  output logic                             wb_reg_w,
  output logic [4:0]                       wb_rd,
  output logic [XLEN-1:0]                  wb_data,
  output logic                             misalign_err,
  output logic [XLEN-1:0]                  fwd_data
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   wdata_q;
  logic [4:0]        rd_q;
  logic              regw_q;
  logic              ld_q;
  logic              cap_en;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_w_q, wb_reg_w_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  logic [OW-1:0]     lane_off;
  logic [NB-1:0]     lanes;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   ld_ext;
  logic              mis_ex;
  int                sz_b;

  // Clears the offset bits below the access size.
  function automatic logic [OW-1:0] size_mask(input logic [1:0] sz);
    return ~OW'((4'd1 << sz) - 4'd1);
  endfunction

  assign lane_off = addr_q[OW-1:0] & size_mask(f3_q[1:0]);
  assign shifted  = dm_rdata >> {lane_off, 3'b000};

  assign ex_ready = (state_q == IDLE);
  assign dm_req   = (state_q == REQ);
  assign dm_addr  = addr_q[ADDR_W-1:OW];
  assign dm_wdata = wdata_q << {lane_off, 3'b000};
  assign dm_we_n  = (state_q == REQ && !ld_q) ? ~lanes : '1;

  assign wb_valid = wb_valid_q;
  assign wb_reg_w = wb_reg_w_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign fwd_data = wb_data_q;

  // An access wider than the bus enables no lanes.
  always_comb begin
    lanes = '0;
    sz_b  = 1 << f3_q[1:0];
    for (int i = 0; i < NB; i++) begin
      if (sz_b <= NB && i >= int'(lane_off) && i < int'(lane_off) + sz_b)
        lanes[i] = 1'b1;
    end
  end

  always_comb begin
    ld_ext = '0;
    case (f3_q)
      3'b000:  ld_ext = XLEN'($signed(shifted[7:0]));
      3'b001:  ld_ext = XLEN'($signed(shifted[15:0]));
      3'b010:  ld_ext = XLEN'($signed(shifted[31:0]));
      3'b011:  ld_ext = (XLEN == 64) ? shifted : '0;
      3'b100:  ld_ext = XLEN'(shifted[7:0]);
      3'b101:  ld_ext = XLEN'(shifted[15:0]);
      3'b110:  ld_ext = (XLEN == 64) ? XLEN'(shifted[31:0]) : '0;
      default: ld_ext = '0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  assign mis_ex = |(ex_addr[OW-1:0] & ~size_mask(ex_func3[1:0]));
  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= ex_valid && ex_ready && (ex_mem_r || ex_mem_w) && mis_ex;
  end
  assign misalign_err = mis_q;
`else
  assign mis_ex       = 1'b0;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cap_en     = 1'b0;
    wb_valid_d = 1'b0;
    wb_reg_w_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    unique case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (ex_mem_r || ex_mem_w) begin
            if (mis_ex) begin
              wb_valid_d = 1'b1;
              wb_rd_d    = ex_rd;
            end else begin
              cap_en  = 1'b1;
              state_d = REQ;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_reg_w_d = ex_reg_w;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_alu;
          end
        end
      end
      REQ: begin
        if (dm_gnt) begin
          if (ld_q) begin
            state_d = WAIT;
          end else begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
          end
        end
      end
      WAIT: begin
        if (dm_rvalid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_reg_w_d = regw_q;
          wb_rd_d    = rd_q;
          wb_data_d  = ld_ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_reg_w_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_w_q <= wb_reg_w_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // A set ex_mem_r wins, so load+store is a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      regw_q  <= 1'b0;
      ld_q    <= 1'b0;
    end else if (cap_en) begin
      addr_q  <= ex_addr;
      f3_q    <= ex_func3;
      wdata_q <= ex_wdata;
      rd_q    <= ex_rd;
      regw_q  <= ex_reg_w;
      ld_q    <= ex_mem_r;
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Parametrised memory-access pipeline stage, successor to the fixed 32-bit single-cycle MEM stage. It sits between EX and WB and drives a data memory over a request/grant/response handshake with variable latency. It generates byte-lane write enables and sign/zero-extends loads for XLEN 32 or 64. It stalls EX while a memory transaction is outstanding and supplies a forwarding value.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
ADDR_W, 16, byte-address width
NB, XLEN/8, bytes per memory word (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
ex_valid  in  1  EX presents an instruction
ex_ready  out  1  stage can accept; 0 = stall EX
ex_mem_r  in  1  load
ex_mem_w  in  1  store
ex_func3  in  3  RISC-V funct3
ex_addr  in  ADDR_W  effective byte address (ALU result)
ex_alu  in  XLEN  non-memory result (ALU or PC+4, already selected)
ex_wdata  in  XLEN  rs2 store data
ex_rd  in  5  destination register
ex_reg_w  in  1  register write
dm_req  out  1  memory request
dm_gnt  in  1  request accepted this cycle
dm_addr  out  ADDR_W-log2(NB)  word address
dm_we_n  out  NB  per-byte write enable, active-low; all 1 = read
dm_wdata  out  XLEN  lane-shifted store data
dm_rvalid  in  1  read data valid
dm_rdata  in  XLEN  read word
wb_valid  out  1  WB holds a retired instruction
wb_reg_w  out  1  write to register file
wb_rd  out  5  destination
wb_data  out  XLEN  writeback value
misalign_err  out  1  misaligned-access exception (see Optional Feature)
fwd_data  out  XLEN  value for EX forwarding

Behaviour:
- Reset: state IDLE; wb_valid, wb_reg_w, misalign_err, dm_req = 0; wb_rd = 0; wb_data = 0; dm_we_n = all 1.
- FSM states: IDLE, REQ, WAIT.
- ex_ready = 1 only in IDLE. An instruction is accepted when ex_valid && ex_ready.
- Non-memory op accepted in IDLE: the next edge sets wb_valid=1, wb_data=ex_alu, and wb_rd/wb_reg_w from EX. State stays IDLE (1-cycle latency).
- Load/store accepted: the stage captures addr, func3, wdata, rd and reg_w, then goes to REQ.
- REQ: dm_req=1, with dm_addr/dm_we_n/dm_wdata held stable until dm_gnt.
  - Store with gnt: go to IDLE; next cycle wb_valid=1, wb_reg_w=0.
  - Load with gnt: go to WAIT.
- WAIT: dm_req=0. On dm_rvalid: extract and extend the data, go to IDLE; next edge sets wb_valid=1, wb_reg_w=captured reg_w.
  - dm_rvalid arriving in the same cycle as dm_gnt is not legal. The memory returns data no earlier than the cycle after gnt.
- wb_valid is 1 for exactly one cycle per retired instruction; otherwise 0.
- Lane offset off = addr[log2(NB)-1:0]. size = 1/2/4/8 bytes from func3[1:0].
- Store lanes: dm_wdata = wdata << 8*off. dm_we_n bits off..off+size-1 = 0, all others = 1.
- Loads: shifted = dm_rdata >> 8*off. Extension by func3:
  - 000 LB, 001 LH: sign-extend
  - 100 LBU, 101 LHU: zero-extend
  - 010 LW: XLEN=32 passes through; XLEN=64 sign-extends
  - 011 LD: XLEN=64 only
  - 110 LWU: XLEN=64 only
  - Any other func3, or a 64-bit op with XLEN=32: result 0.
- A store whose func3[1:0]=11 with XLEN=32 performs no write (dm_we_n all 1) but still completes the handshake.
- fwd_data = wb_data; the EX hazard unit uses wb_valid && wb_reg_w.
- Reset asserted in REQ or WAIT: return to IDLE, drop dm_req, emit no wb_valid. A later stray dm_rvalid in IDLE is ignored.
- ex_mem_r && ex_mem_w both set: treated as load.

Optional Feature:
Macro: LSU_MISALIGN_TRAP_EN.
- Defined: off not a multiple of size → no dm_req, state stays IDLE. Next edge sets wb_valid=1, wb_reg_w=0, misalign_err=1 for one cycle.
- Undefined: misalign_err tied 0. off is masked to size alignment (low log2(size) bits cleared) and the access proceeds.

Test Plan:
- XLEN=32, SB addr 0x0003, wdata 0x000000A5, gnt same cycle as REQ → dm_we_n=0111, dm_wdata=0xA5000000, ex_ready low 1 cycle, wb_reg_w=0.
- XLEN=32, LH addr 0x0002, rvalid 3 cycles after gnt, rdata 0x8001_1234 → ex_ready low for REQ+WAIT, then wb_data=0xFFFF8001, wb_valid 1 cycle.
- XLEN=64, LWU addr 0x0004, rdata 0x8000_0000_0000_0000 → wb_data=0x0000_0000_8000_0000; LD from the same word → full 64-bit value.
- Back-to-back ALU op then LW: ALU wb_valid next cycle; LW stalls EX until rvalid; dm_req held across 2 cycles without gnt with stable addr and lanes.
- rst pulsed in WAIT, then dm_rvalid=1 → no wb_valid, dm_req=0, state IDLE, ex_ready=1.
- With LSU_MISALIGN_TRAP_EN: SW addr 0x0002 → no dm_req, misalign_err=1 one cycle. Without: dm_addr word 0, dm_we_n=0000.
